// File: rtl/qr_stream_arb_if.sv
// Requester, QR-pipeline and result signals of the frame arbiter, bundled with
// arbiter-side (slave) and environment-side (master) views.
interface qr_stream_arb_if #(
  parameter int unsigned DW = 17
);
  localparam int unsigned W = 4 * DW;

  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         pe_valid;
  logic [W-1:0] pe_in;
  logic [W-1:0] pe_out;
  logic         res_valid;
  logic         res_src;
  logic         res_last;
  logic [W-1:0] res_data;
  logic         busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, pe_out,
    output req0_ready, req1_ready, pe_valid, pe_in,
           res_valid, res_src, res_last, res_data, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, pe_out,
    input  req0_ready, req1_ready, pe_valid, pe_in,
           res_valid, res_src, res_last, res_data, busy
  );
endinterface

// File: rtl/qr_stream_arb.sv
// Frame-locked round-robin arbiter sharing one fixed-latency QR pipeline
// between two requesters, with a tag pipe that labels each returning beat.
module qr_stream_arb #(
  parameter int unsigned DW   = 17,
  parameter int unsigned ROWS = 4,
  parameter int unsigned LAT  = 20
) (
  input logic             clk,
  input logic             rst_n,
  qr_stream_arb_if.slave  bus
);
  localparam int unsigned W  = 4 * DW;
  localparam int unsigned CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ROWS - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  typedef struct packed {
    logic v;
    logic src;
    logic last;
  } tag_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          rr, rr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ready0, ready1;
  logic          xfer, last_beat, busy_nxt;
  logic [W-1:0]  beat;

  logic          pe_valid;
  logic [W-1:0]  pe_in;
  logic          pe_src, pe_last;
  tag_t          tag [LAT];
  logic          busy;

  // Next-state, grant and busy decode
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    xfer      = (ready0 & bus.req0_valid) | (ready1 & bus.req1_valid);
    last_beat = xfer && (cnt == LAST_CNT);
    beat      = owner ? bus.req1_data : bus.req0_data;

    case (state)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          state_nxt = LOCK;
          owner_nxt = rr;
        end else if (bus.req0_valid) begin
          state_nxt = LOCK;
          owner_nxt = 1'b0;
        end else if (bus.req1_valid) begin
          state_nxt = LOCK;
          owner_nxt = 1'b1;
        end
      end
      LOCK: begin
        if (last_beat) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rr_nxt    = ~owner;
        end else if (xfer) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Busy one cycle ahead: lock, the beat about to issue, or any tag that stays in the pipe
    busy_nxt = (state_nxt == LOCK) | xfer | pe_valid;
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      busy_nxt = busy_nxt | tag[i].v;
    end
  end

  // Arbiter state and registered grants
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      rr     <= 1'b0;
      cnt    <= '0;
      ready0 <= 1'b0;
      ready1 <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr     <= rr_nxt;
      cnt    <= cnt_nxt;
      ready0 <= (state_nxt == LOCK) && !owner_nxt;
      ready1 <= (state_nxt == LOCK) && owner_nxt;
      busy   <= busy_nxt;
    end
  end

  // Pipeline issue stage and tag pipe aligned to the pipeline latency
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pe_valid <= 1'b0;
      pe_in    <= '0;
      pe_src   <= 1'b0;
      pe_last  <= 1'b0;
      for (int i = 0; i < int'(LAT); i++) begin
        tag[i] <= '0;
      end
    end else begin
      pe_valid <= xfer;
      pe_in    <= xfer ? beat : '0;
      pe_src   <= xfer & owner;
      pe_last  <= last_beat;
      tag[0]   <= '{v: pe_valid, src: pe_src, last: pe_last};
      for (int i = 1; i < int'(LAT); i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.pe_valid   = pe_valid;
  assign bus.pe_in      = pe_in;
  assign bus.res_valid  = tag[LAT-1].v;
  assign bus.res_src    = tag[LAT-1].src;
  assign bus.res_last   = tag[LAT-1].last;
  // Pipeline output arrives in the same cycle as its tag, so it is only gated here
  assign bus.res_data   = tag[LAT-1].v ? bus.pe_out : '0;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_qr_stream_arb.sv
// Directed-plus-random bench for qr_stream_arb against a frame/time-schedule model.
module tb_qr_stream_arb;
  localparam int unsigned DW   = 17;
  localparam int unsigned ROWS = 4;
  localparam int unsigned LAT  = 20;
  localparam int unsigned W    = 4 * DW;
  localparam int          RING = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qr_stream_arb_if #(.DW(DW)) bus_if ();

  qr_stream_arb #(.DW(DW), .ROWS(ROWS), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Stand-in for the QR pipeline: pure LAT-cycle delay of pe_in
  logic [W-1:0] dly [LAT];
  always @(posedge clk) begin
    dly[0] <= bus_if.pe_in;
    for (int i = 1; i < int'(LAT); i++) dly[i] <= dly[i-1];
  end
  assign bus_if.pe_out = dly[LAT-1];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_last [2];

  // Reference model: frame lock, beats left, round-robin, and a cycle-indexed schedule
  bit           locked;
  bit           own;
  bit           rr_m;
  int           left;
  int           last_pe;
  bit           sp_v [RING];
  logic [W-1:0] sp_d [RING];
  bit           sr_v [RING];
  bit           sr_s [RING];
  bit           sr_l [RING];
  logic [W-1:0] sr_d [RING];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0]  r;
    logic [DW-1:0] el;
    r = '0;
    for (int e = 0; e < 4; e++) begin
      case ($urandom_range(0, 3))
        0:       el = 17'h10000;   // -65536
        1:       el = 17'h0FFFF;   //  65535
        default: el = DW'($urandom);
      endcase
      r[e*DW +: DW] = el;
    end
    return r;
  endfunction

  task automatic model_clear();
    locked  = 1'b0;
    own     = 1'b0;
    rr_m    = 1'b0;
    left    = 0;
    last_pe = -1000;
    for (int i = 0; i < RING; i++) begin
      sp_v[i] = 1'b0; sp_d[i] = '0;
      sr_v[i] = 1'b0; sr_s[i] = 1'b0; sr_l[i] = 1'b0; sr_d[i] = '0;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b1;
    bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
    bus_if.req0_data  = '0;   bus_if.req1_data  = '0;
    for (int k = 0; k < n; k++) begin
      #1;
      check("rst_req0_ready", W'(bus_if.req0_ready), '0);
      check("rst_req1_ready", W'(bus_if.req1_ready), '0);
      check("rst_pe_valid",   W'(bus_if.pe_valid),   '0);
      check("rst_pe_in",      bus_if.pe_in,          '0);
      check("rst_res_valid",  W'(bus_if.res_valid),  '0);
      check("rst_res_src",    W'(bus_if.res_src),    '0);
      check("rst_res_last",   W'(bus_if.res_last),   '0);
      check("rst_res_data",   bus_if.res_data,       '0);
      check("rst_busy",       W'(bus_if.busy),       '0);
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    model_clear();
    rst_n = 1'b0;
  endtask

  task automatic step(input bit v0, input bit v1);
    int           idx, pi, ri;
    bit           er0, er1, x, eb;
    logic [W-1:0] d0, d1;
    d0 = rand_beat();
    d1 = rand_beat();
    bus_if.req0_valid = v0; bus_if.req0_data = d0;
    bus_if.req1_valid = v1; bus_if.req1_data = d1;
    #1;
    idx = cyc % RING;
    er0 = locked && !own;
    er1 = locked && own;
    check("req0_ready", W'(bus_if.req0_ready), W'(er0));
    check("req1_ready", W'(bus_if.req1_ready), W'(er1));
    check("pe_valid",   W'(bus_if.pe_valid),   W'(sp_v[idx]));
    check("pe_in",      bus_if.pe_in,          sp_v[idx] ? sp_d[idx] : '0);
    check("res_valid",  W'(bus_if.res_valid),  W'(sr_v[idx]));
    check("res_src",    W'(bus_if.res_src),    W'(sr_v[idx] & sr_s[idx]));
    check("res_last",   W'(bus_if.res_last),   W'(sr_v[idx] & sr_l[idx]));
    check("res_data",   bus_if.res_data,       sr_v[idx] ? sr_d[idx] : '0);
    if (sp_v[idx]) last_pe = cyc;
    eb = locked || (cyc - last_pe <= int'(LAT));
    check("busy", W'(bus_if.busy), W'(eb));
    if (bus_if.res_valid === 1'b1 && bus_if.res_last === 1'b1)
      n_last[bus_if.res_src ? 1 : 0]++;
    sp_v[idx] = 1'b0;
    sr_v[idx] = 1'b0;

    x = (er0 && v0) || (er1 && v1);
    if (!locked) begin
      if (v0 || v1) begin
        locked = 1'b1;
        own    = (v0 && v1) ? rr_m : v1;
        left   = ROWS;
      end
    end else if (x) begin
      pi = (cyc + 1) % RING;
      ri = (cyc + 1 + int'(LAT)) % RING;
      sp_v[pi] = 1'b1; sp_d[pi] = own ? d1 : d0;
      sr_v[ri] = 1'b1; sr_s[ri] = own; sr_l[ri] = (left == 1);
      sr_d[ri] = own ? d1 : d0;
      left--;
      if (left == 0) begin
        locked = 1'b0;
        rr_m   = ~own;
      end
    end
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < int'(LAT) + 6; k++) step(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
    bus_if.req0_data  = '0;   bus_if.req1_data  = '0;
    model_clear();
    @(negedge clk);
    do_reset(3);

    // Single requester, valid held from the idle cycle
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    drain();

    // Contention straight out of reset: req0 first, then req1
    do_reset(2);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1);
    drain();

    // Owner bubble: req1 owns, drops valid for 3 cycles after beat 2
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1);
    drain();

    // Fairness over 40 back-to-back frames
    n_last[0] = 0; n_last[1] = 0;
    for (int k = 0; k < 40 * (int'(ROWS) + 1); k++) step(1'b1, 1'b1);
    drain();
    check("frames_req0", W'(n_last[0]), W'(20));
    check("frames_req1", W'(n_last[1]), W'(20));

    // Reset after beat 3 of a frame; pending results must vanish
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    do_reset(2);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
    drain();

    // Random valids
    for (int k = 0; k < 300; k++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
